// File: rtl/scan_code_ascii.sv
// PS/2 set-2 scan code to ASCII translator: strips make/break/extended/pause
// framing, tracks shift/ctrl/caps-lock and holds one character for the consumer.
module scan_code_ascii #(
    parameter logic [7:0] ENTER_BYTE = 8'h0D,
    parameter int         PAUSE_SKIP = 7
) (
    input  logic       clk,
    input  logic       reset_low,
    output logic       scan_code_ready,
    input  logic       scan_code_valid,
    input  logic [7:0] scan_code_byte,
    input  logic       character_ready,
    output logic       character_valid,
    output logic [7:0] character_byte,
    output logic       caps_lock
);

    typedef enum logic [2:0] {IDLE, BREAK, EXT, EXT_BREAK, PAUSE} state_t;

    state_t     state_r;
    logic [7:0] skip_cnt_r;
    logic       lshift_r, rshift_r, lctrl_r, rctrl_r;
    logic       caps_held_r, caps_lock_r;
    logic       char_valid_r;
    logic [7:0] char_byte_r;

    logic       accept_s, ctrl_byte_s, shift_s, ctrl_s;
    logic [8:0] letter_s;
    logic [16:0] symbol_s;
    logic       make_hit_s, ext_hit_s;
    logic [7:0] make_byte_s, ext_byte_s;

    // Letter make code to {hit, lowercase ASCII}.
    function automatic logic [8:0] letter_lookup(input logic [7:0] code);
        case (code)
            8'h1C: letter_lookup = {1'b1, 8'h61};
            8'h32: letter_lookup = {1'b1, 8'h62};
            8'h21: letter_lookup = {1'b1, 8'h63};
            8'h23: letter_lookup = {1'b1, 8'h64};
            8'h24: letter_lookup = {1'b1, 8'h65};
            8'h2B: letter_lookup = {1'b1, 8'h66};
            8'h34: letter_lookup = {1'b1, 8'h67};
            8'h33: letter_lookup = {1'b1, 8'h68};
            8'h43: letter_lookup = {1'b1, 8'h69};
            8'h3B: letter_lookup = {1'b1, 8'h6A};
            8'h42: letter_lookup = {1'b1, 8'h6B};
            8'h4B: letter_lookup = {1'b1, 8'h6C};
            8'h3A: letter_lookup = {1'b1, 8'h6D};
            8'h31: letter_lookup = {1'b1, 8'h6E};
            8'h44: letter_lookup = {1'b1, 8'h6F};
            8'h4D: letter_lookup = {1'b1, 8'h70};
            8'h15: letter_lookup = {1'b1, 8'h71};
            8'h2D: letter_lookup = {1'b1, 8'h72};
            8'h1B: letter_lookup = {1'b1, 8'h73};
            8'h2C: letter_lookup = {1'b1, 8'h74};
            8'h3C: letter_lookup = {1'b1, 8'h75};
            8'h2A: letter_lookup = {1'b1, 8'h76};
            8'h1D: letter_lookup = {1'b1, 8'h77};
            8'h22: letter_lookup = {1'b1, 8'h78};
            8'h35: letter_lookup = {1'b1, 8'h79};
            8'h1A: letter_lookup = {1'b1, 8'h7A};
            default: letter_lookup = {1'b0, 8'h00};
        endcase
    endfunction

    // Non-letter make code to {hit, unshifted, shifted}; fixed keys ignore shift.
    function automatic logic [16:0] symbol_lookup(input logic [7:0] code);
        case (code)
            8'h16: symbol_lookup = {1'b1, 8'h31, 8'h21};
            8'h1E: symbol_lookup = {1'b1, 8'h32, 8'h40};
            8'h26: symbol_lookup = {1'b1, 8'h33, 8'h23};
            8'h25: symbol_lookup = {1'b1, 8'h34, 8'h24};
            8'h2E: symbol_lookup = {1'b1, 8'h35, 8'h25};
            8'h36: symbol_lookup = {1'b1, 8'h36, 8'h5E};
            8'h3D: symbol_lookup = {1'b1, 8'h37, 8'h26};
            8'h3E: symbol_lookup = {1'b1, 8'h38, 8'h2A};
            8'h46: symbol_lookup = {1'b1, 8'h39, 8'h28};
            8'h45: symbol_lookup = {1'b1, 8'h30, 8'h29};
            8'h4E: symbol_lookup = {1'b1, 8'h2D, 8'h5F};
            8'h55: symbol_lookup = {1'b1, 8'h3D, 8'h2B};
            8'h54: symbol_lookup = {1'b1, 8'h5B, 8'h7B};
            8'h5B: symbol_lookup = {1'b1, 8'h5D, 8'h7D};
            8'h5D: symbol_lookup = {1'b1, 8'h5C, 8'h7C};
            8'h4C: symbol_lookup = {1'b1, 8'h3B, 8'h3A};
            8'h52: symbol_lookup = {1'b1, 8'h27, 8'h22};
            8'h41: symbol_lookup = {1'b1, 8'h2C, 8'h3C};
            8'h49: symbol_lookup = {1'b1, 8'h2E, 8'h3E};
            8'h4A: symbol_lookup = {1'b1, 8'h2F, 8'h3F};
            8'h0E: symbol_lookup = {1'b1, 8'h60, 8'h7E};
            8'h5A: symbol_lookup = {1'b1, ENTER_BYTE, ENTER_BYTE};
            8'h66: symbol_lookup = {1'b1, 8'h08, 8'h08};
            8'h29: symbol_lookup = {1'b1, 8'h20, 8'h20};
            8'h0D: symbol_lookup = {1'b1, 8'h09, 8'h09};
            8'h76: symbol_lookup = {1'b1, 8'h1B, 8'h1B};
            default: symbol_lookup = {1'b0, 8'h00, 8'h00};
        endcase
    endfunction

    assign scan_code_ready = ~char_valid_r;
    assign character_valid = char_valid_r;
    assign character_byte  = char_byte_r;
    assign caps_lock       = caps_lock_r;

    // Decode the incoming byte against current modifier state.
    always_comb begin
        accept_s    = scan_code_valid & ~char_valid_r;
        ctrl_byte_s = (scan_code_byte == 8'hAA) | (scan_code_byte == 8'hFA) |
                      (scan_code_byte == 8'hEE) | (scan_code_byte == 8'hFE) |
                      (scan_code_byte == 8'h00) | (scan_code_byte == 8'hFF);
        shift_s     = lshift_r | rshift_r;
        ctrl_s      = lctrl_r | rctrl_r;
        letter_s    = letter_lookup(scan_code_byte);
        symbol_s    = symbol_lookup(scan_code_byte);
        make_hit_s  = 1'b0;
        make_byte_s = 8'h00;
        if (letter_s[8]) begin
            make_hit_s = 1'b1;
            if (ctrl_s) begin
                make_byte_s = letter_s[7:0] & 8'h1F;
            end else if (shift_s ^ caps_lock_r) begin
                make_byte_s = letter_s[7:0] & 8'hDF;
            end else begin
                make_byte_s = letter_s[7:0];
            end
        end else if (symbol_s[16]) begin
            make_hit_s  = 1'b1;
            make_byte_s = shift_s ? symbol_s[7:0] : symbol_s[15:8];
        end else begin
            make_hit_s  = 1'b0;
        end
        case (scan_code_byte)
            8'h5A:   begin ext_hit_s = 1'b1; ext_byte_s = ENTER_BYTE; end
            8'h4A:   begin ext_hit_s = 1'b1; ext_byte_s = 8'h2F;      end
            default: begin ext_hit_s = 1'b0; ext_byte_s = 8'h00;      end
        endcase
    end

    // Framing FSM, modifier tracking and the single-entry output register.
    always_ff @(posedge clk or negedge reset_low) begin
        if (!reset_low) begin
            state_r      <= IDLE;
            skip_cnt_r   <= 8'h00;
            lshift_r     <= 1'b0;
            rshift_r     <= 1'b0;
            lctrl_r      <= 1'b0;
            rctrl_r      <= 1'b0;
            caps_held_r  <= 1'b0;
            caps_lock_r  <= 1'b0;
            char_valid_r <= 1'b0;
            char_byte_r  <= 8'h00;
        end else begin
            if (char_valid_r && character_ready) begin
                char_valid_r <= 1'b0;
            end
            if (accept_s) begin
                if (state_r == PAUSE) begin
                    skip_cnt_r <= skip_cnt_r - 8'd1;
                    if (skip_cnt_r <= 8'd1) begin
                        state_r <= IDLE;
                    end
                end else if (ctrl_byte_s) begin
                    state_r <= IDLE;
                end else begin
                    case (state_r)
                        IDLE: begin
                            case (scan_code_byte)
                                8'hE0: state_r <= EXT;
                                8'hF0: state_r <= BREAK;
                                8'hE1: begin
                                    state_r    <= PAUSE;
                                    skip_cnt_r <= 8'(PAUSE_SKIP);
                                end
                                8'h12: lshift_r <= 1'b1;
                                8'h59: rshift_r <= 1'b1;
                                8'h14: lctrl_r  <= 1'b1;
                                8'h58: begin
                                    if (!caps_held_r) begin
                                        caps_lock_r <= ~caps_lock_r;
                                    end
                                    caps_held_r <= 1'b1;
                                end
                                default: begin
                                    if (make_hit_s) begin
                                        char_valid_r <= 1'b1;
                                        char_byte_r  <= make_byte_s;
                                    end
                                end
                            endcase
                        end
                        BREAK: begin
                            state_r <= IDLE;
                            case (scan_code_byte)
                                8'h12:   lshift_r    <= 1'b0;
                                8'h59:   rshift_r    <= 1'b0;
                                8'h14:   lctrl_r     <= 1'b0;
                                8'h58:   caps_held_r <= 1'b0;
                                default: state_r     <= IDLE;
                            endcase
                        end
                        EXT: begin
                            if (scan_code_byte == 8'hF0) begin
                                state_r <= EXT_BREAK;
                            end else begin
                                state_r <= IDLE;
                                if (scan_code_byte == 8'h14) begin
                                    rctrl_r <= 1'b1;
                                end
                                if (ext_hit_s) begin
                                    char_valid_r <= 1'b1;
                                    char_byte_r  <= ext_byte_s;
                                end
                            end
                        end
                        EXT_BREAK: begin
                            state_r <= IDLE;
                            if (scan_code_byte == 8'h14) begin
                                rctrl_r <= 1'b0;
                            end
                        end
                        default: state_r <= IDLE;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_scan_code_ascii.sv
// Bench for scan_code_ascii: directed scenarios plus random scan-code streams
// checked against a key-state model of the keyboard.
module tb_scan_code_ascii;

    localparam logic [7:0] ENTER = 8'h0D;
    localparam int         SKIP  = 7;

    logic       clk, reset_low;
    logic       scan_code_ready, scan_code_valid;
    logic [7:0] scan_code_byte;
    logic       character_ready, character_valid;
    logic [7:0] character_byte;
    logic       caps_lock;

    int checks = 0;
    int errors = 0;

    scan_code_ascii #(.ENTER_BYTE(ENTER), .PAUSE_SKIP(SKIP)) dut (
        .clk(clk), .reset_low(reset_low),
        .scan_code_ready(scan_code_ready), .scan_code_valid(scan_code_valid),
        .scan_code_byte(scan_code_byte),
        .character_ready(character_ready), .character_valid(character_valid),
        .character_byte(character_byte), .caps_lock(caps_lock)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Keyboard model: which keys are down, caps state and pending prefixes.
    logic [7:0] letter_code [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
        8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
        8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    logic [7:0] sym_code [21] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
        8'h3E, 8'h46, 8'h45, 8'h4E, 8'h55, 8'h54, 8'h5B, 8'h5D, 8'h4C, 8'h52, 8'h41,
        8'h49, 8'h4A, 8'h0E};
    logic [7:0] sym_plain [21] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37,
        8'h38, 8'h39, 8'h30, 8'h2D, 8'h3D, 8'h5B, 8'h5D, 8'h5C, 8'h3B, 8'h27, 8'h2C,
        8'h2E, 8'h2F, 8'h60};
    logic [7:0] sym_shift [21] = '{8'h21, 8'h40, 8'h23, 8'h24, 8'h25, 8'h5E, 8'h26,
        8'h2A, 8'h28, 8'h29, 8'h5F, 8'h2B, 8'h7B, 8'h7D, 8'h7C, 8'h3A, 8'h22, 8'h3C,
        8'h3E, 8'h3F, 8'h7E};
    logic [7:0] fixed_code [5] = '{8'h5A, 8'h66, 8'h29, 8'h0D, 8'h76};
    logic [7:0] fixed_char [5] = '{ENTER, 8'h08, 8'h20, 8'h09, 8'h1B};

    bit held_n [256];
    bit held_e [256];
    bit m_caps, m_ext, m_brk;
    int m_pause;

    task automatic model_reset();
        for (int i = 0; i < 256; i++) begin
            held_n[i] = 1'b0;
            held_e[i] = 1'b0;
        end
        m_caps = 1'b0; m_ext = 1'b0; m_brk = 1'b0; m_pause = 0;
    endtask

    task automatic model_make(input bit ext, input logic [7:0] b,
                              output bit hit, output logic [7:0] ch);
        bit shift, ctrl;
        logic [7:0] lower;
        hit = 1'b0; ch = 8'h00;
        if (ext) begin
            held_e[b] = 1'b1;
            if (b == 8'h5A) begin hit = 1'b1; ch = ENTER; end
            if (b == 8'h4A) begin hit = 1'b1; ch = 8'h2F; end
            return;
        end
        if (b == 8'h58 && !held_n[8'h58]) m_caps = ~m_caps;
        held_n[b] = 1'b1;
        shift = held_n[8'h12] | held_n[8'h59];
        ctrl  = held_n[8'h14] | held_e[8'h14];
        for (int i = 0; i < 26; i++) begin
            if (letter_code[i] == b) begin
                lower = 8'h61 + 8'(i);
                hit = 1'b1;
                ch = ctrl ? 8'(i + 1) : ((shift ^ m_caps) ? lower - 8'h20 : lower);
            end
        end
        for (int i = 0; i < 21; i++) begin
            if (sym_code[i] == b) begin
                hit = 1'b1;
                ch = shift ? sym_shift[i] : sym_plain[i];
            end
        end
        for (int i = 0; i < 5; i++) begin
            if (fixed_code[i] == b) begin
                hit = 1'b1;
                ch = fixed_char[i];
            end
        end
    endtask

    task automatic model_step(input logic [7:0] b, output bit hit, output logic [7:0] ch);
        hit = 1'b0; ch = 8'h00;
        if (m_pause > 0) begin
            m_pause--;
        end else if (b inside {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF}) begin
            m_ext = 1'b0; m_brk = 1'b0;
        end else if (!m_ext && !m_brk) begin
            if (b == 8'hE0) m_ext = 1'b1;
            else if (b == 8'hF0) m_brk = 1'b1;
            else if (b == 8'hE1) m_pause = SKIP;
            else model_make(1'b0, b, hit, ch);
        end else if (m_ext && !m_brk) begin
            if (b == 8'hF0) m_brk = 1'b1;
            else begin m_ext = 1'b0; model_make(1'b1, b, hit, ch); end
        end else begin
            if (m_ext) held_e[b] = 1'b0;
            else held_n[b] = 1'b0;
            m_ext = 1'b0; m_brk = 1'b0;
        end
    endtask

    // want: -1 = use model result, -2 = expect no character, 0..255 = expected byte.
    // Called and returns on a falling clock edge.
    task automatic send_byte(input logic [7:0] b, input int want, input bit pop);
        bit hit;
        logic [7:0] exp;
        int n;
        model_step(b, hit, exp);
        if (want >= 0) begin hit = 1'b1; exp = 8'(want); end
        if (want == -2) hit = 1'b0;
        scan_code_valid = 1'b1;
        scan_code_byte  = b;
        n = 0;
        while (!scan_code_ready && n < 20) begin @(negedge clk); n++; end
        if (!scan_code_ready) begin
            checks++; errors++;
            $display("FAIL accept_timeout: byte %h never accepted", b);
            scan_code_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        scan_code_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (character_valid !== hit) begin
            errors++;
            $display("FAIL valid_after_%h: got %b expected %b", b, character_valid, hit);
        end
        if (hit) begin
            checks++;
            if (character_byte !== exp) begin
                errors++;
                $display("FAIL char_after_%h: got %h expected %h", b, character_byte, exp);
            end
            if (pop) begin
                repeat ($urandom_range(0, 3)) begin
                    @(negedge clk);
                    checks++;
                    if (character_valid !== 1'b1 || character_byte !== exp || scan_code_ready !== 1'b0) begin
                        errors++;
                        $display("FAIL hold_%h: valid %b byte %h ready %b expected 1 %h 0",
                                 b, character_valid, character_byte, scan_code_ready, exp);
                    end
                end
                character_ready = 1'b1;
                @(negedge clk);
                character_ready = 1'b0;
                checks++;
                if (character_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL drain_%h: valid %b expected 0", b, character_valid);
                end
            end
        end
        checks++;
        if (caps_lock !== m_caps) begin
            errors++;
            $display("FAIL caps_after_%h: got %b expected %b", b, caps_lock, m_caps);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (character_valid !== 1'b0 || character_byte !== 8'h00 ||
            caps_lock !== 1'b0 || scan_code_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s: valid %b byte %h caps %b ready %b expected 0 00 0 1", tag,
                     character_valid, character_byte, caps_lock, scan_code_ready);
        end
    endtask

    task automatic pulse_reset(input string tag);
        #2 reset_low = 1'b0;
        #1 check_reset_outputs(tag);
        model_reset();
        @(negedge clk);
        reset_low = 1'b1;
    endtask

    task automatic test_reset();
        reset_low = 1'b0; scan_code_valid = 1'b0; scan_code_byte = 8'h00;
        character_ready = 1'b0;
        model_reset();
        #3 check_reset_outputs("reset_async");
        repeat (2) @(negedge clk);
        reset_low = 1'b1;
        @(negedge clk);
        check_reset_outputs("reset_release");
    endtask

    task automatic test_letters();
        send_byte(8'h1C, 8'h61, 1'b1);
        send_byte(8'h1C, 8'h61, 1'b1);
        send_byte(8'hF0, -2, 1'b1);
        send_byte(8'h1C, -2, 1'b1);
        send_byte(8'h1C, 8'h61, 1'b1);
        send_byte(8'h66, 8'h08, 1'b1);
        send_byte(8'h5A, 8'h0D, 1'b1);
        send_byte(8'h13, -2, 1'b1);
    endtask

    task automatic test_shift();
        send_byte(8'h12, -2, 1'b1);
        send_byte(8'h1C, 8'h41, 1'b1);
        send_byte(8'hF0, -2, 1'b1);
        send_byte(8'h12, -2, 1'b1);
        send_byte(8'h1C, 8'h61, 1'b1);
        send_byte(8'h59, -2, 1'b1);
        send_byte(8'h16, 8'h21, 1'b1);
        send_byte(8'h52, 8'h22, 1'b1);
        send_byte(8'hF0, -2, 1'b1);
        send_byte(8'h59, -2, 1'b1);
        send_byte(8'h52, 8'h27, 1'b1);
    endtask

    task automatic test_caps();
        send_byte(8'h58, -2, 1'b1);
        checks++;
        if (caps_lock !== 1'b1) begin errors++; $display("FAIL caps_on: got %b expected 1", caps_lock); end
        send_byte(8'hF0, -2, 1'b1);
        send_byte(8'h58, -2, 1'b1);
        send_byte(8'h58, -2, 1'b1);
        send_byte(8'h58, -2, 1'b1);
        checks++;
        if (caps_lock !== 1'b0) begin errors++; $display("FAIL caps_repeat: got %b expected 0", caps_lock); end
        send_byte(8'hF0, -2, 1'b1);
        send_byte(8'h58, -2, 1'b1);
        send_byte(8'h1C, 8'h61, 1'b1);
        send_byte(8'h58, -2, 1'b1);
        send_byte(8'hF0, -2, 1'b1);
        send_byte(8'h58, -2, 1'b1);
        send_byte(8'h1C, 8'h41, 1'b1);
        send_byte(8'h12, -2, 1'b1);
        send_byte(8'h1C, 8'h61, 1'b1);
        send_byte(8'hF0, -2, 1'b1);
        send_byte(8'h12, -2, 1'b1);
        send_byte(8'h58, -2, 1'b1);
        send_byte(8'hF0, -2, 1'b1);
        send_byte(8'h58, -2, 1'b1);
    endtask

    task automatic test_ctrl();
        send_byte(8'h14, -2, 1'b1);
        send_byte(8'h21, 8'h03, 1'b1);
        send_byte(8'h16, 8'h31, 1'b1);
        send_byte(8'hF0, -2, 1'b1);
        send_byte(8'h14, -2, 1'b1);
        send_byte(8'hE0, -2, 1'b1);
        send_byte(8'h14, -2, 1'b1);
        send_byte(8'h1A, 8'h1A, 1'b1);
        send_byte(8'hE0, -2, 1'b1);
        send_byte(8'hF0, -2, 1'b1);
        send_byte(8'h14, -2, 1'b1);
        send_byte(8'h21, 8'h63, 1'b1);
        send_byte(8'hE0, -2, 1'b1);
        send_byte(8'h4A, 8'h2F, 1'b1);
        send_byte(8'hE0, -2, 1'b1);
        send_byte(8'h1C, -2, 1'b1);
        send_byte(8'hE0, -2, 1'b1);
        send_byte(8'hAA, -2, 1'b1);
        send_byte(8'h1C, 8'h61, 1'b1);
    endtask

    task automatic test_pause();
        logic [7:0] seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        for (int i = 0; i < 8; i++) send_byte(seq[i], -2, 1'b1);
        send_byte(8'h1C, 8'h61, 1'b1);
        send_byte(8'h21, 8'h63, 1'b1);
    endtask

    task automatic test_back_to_back();
        send_byte(8'h1C, 8'h61, 1'b0);
        scan_code_valid = 1'b1;
        scan_code_byte  = 8'h32;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (scan_code_ready !== 1'b0 || character_valid !== 1'b1 || character_byte !== 8'h61) begin
                errors++;
                $display("FAIL backpressure_%0d: ready %b valid %b byte %h expected 0 1 61",
                         i, scan_code_ready, character_valid, character_byte);
            end
        end
        scan_code_valid = 1'b0;
        character_ready = 1'b1;
        @(negedge clk);
        character_ready = 1'b0;
        checks++;
        if (character_valid !== 1'b0 || scan_code_ready !== 1'b1) begin
            errors++;
            $display("FAIL backpressure_release: valid %b ready %b expected 0 1",
                     character_valid, scan_code_ready);
        end
        send_byte(8'h32, 8'h62, 1'b1);
    endtask

    task automatic test_reset_mid();
        send_byte(8'h58, -2, 1'b1);
        send_byte(8'hF0, -2, 1'b1);
        send_byte(8'h58, -2, 1'b1);
        send_byte(8'h12, -2, 1'b1);
        send_byte(8'hE0, -2, 1'b1);
        pulse_reset("reset_mid_ext");
        send_byte(8'h5A, 8'h0D, 1'b1);
        send_byte(8'h1C, 8'h61, 1'b1);
        send_byte(8'h23, 8'h64, 1'b0);
        pulse_reset("reset_pending_char");
        send_byte(8'h23, 8'h64, 1'b1);
    endtask

    task automatic test_random();
        logic [7:0] b;
        int r;
        for (int n = 0; n < 400; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 25) b = letter_code[$urandom_range(0, 25)];
            else if (r < 40) b = sym_code[$urandom_range(0, 20)];
            else if (r < 44) b = fixed_code[$urandom_range(0, 4)];
            else if (r < 58) begin
                case ($urandom_range(0, 3))
                    0: b = 8'h12;
                    1: b = 8'h59;
                    2: b = 8'h14;
                    default: b = 8'h58;
                endcase
            end
            else if (r < 76) b = 8'hF0;
            else if (r < 86) b = 8'hE0;
            else if (r < 88) b = 8'hE1;
            else if (r < 92) b = 8'hAA;
            else b = 8'($urandom_range(0, 255));
            send_byte(b, -1, 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_letters();
        test_shift();
        test_caps();
        test_ctrl();
        test_pause();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
